// File: rtl/prim_sram_responder_pkg.sv
// Shared types and constants for the SRAM responder.
package prim_sram_responder_pkg;

    // Responder lifecycle: zero-fill after reset, then serve requests forever.
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    // Width of the response error field.
    localparam int unsigned ErrW = 2;

    // Error codes; bit 0 flags a parity mismatch, bit 1 a rejected access.
    localparam logic [ErrW-1:0] ErrNone   = 2'b00;
    localparam logic [ErrW-1:0] ErrReject = 2'b10;

endpackage

// File: rtl/prim_sram_responder_mem.sv
// Depth x Width storage with synchronous write and a registered, write-first read.
module prim_sram_responder_mem #(
    parameter int unsigned Depth = 4096,
    parameter int unsigned Width = 33,
    parameter int unsigned IdxW  = 12
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [IdxW-1:0]  idx,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    // Array write and read register; the read register holds between reads.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
        if (re) begin
            rdata_q <= we ? wdata : mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/prim_sram_responder.sv
// SRAM target: zero-fills after reset, then serves in-order fixed-latency reads
// and parity-protected writes with no backpressure.
module prim_sram_responder
    import prim_sram_responder_pkg::*;
#(
    parameter int unsigned SramDw  = 32,
    parameter int unsigned SramAw  = 12,
    parameter int unsigned Depth   = 4096,
    parameter int unsigned Latency = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sram_req_i,
    input  logic [SramAw-1:0] sram_addr_i,
    input  logic              sram_write_i,
    input  logic [SramDw-1:0] sram_wdata_i,
    input  logic              inj_perr_i,
    output logic              sram_rvalid_o,
    output logic [SramDw-1:0] sram_rdata_o,
    output logic [ErrW-1:0]   sram_rerror_o,
    output logic              init_done_o
);

    localparam int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned WordW = SramDw + 1;

    typedef struct packed {
        logic              valid;
        logic [SramDw-1:0] data;
        logic [ErrW-1:0]   err;
    } resp_t;

    // Elaboration-time parameter range checks.
    if (Latency < 1 || Latency > 4) begin : g_bad_latency
        $error("prim_sram_responder: Latency must be in 1..4");
    end
    if (Depth < 2 || 64'(Depth) > (64'd1 << SramAw)) begin : g_bad_depth
        $error("prim_sram_responder: Depth must be in 2..2**SramAw");
    end

    state_e          state_q, state_d;
    logic [IdxW-1:0] init_cnt_q, init_cnt_d;
    logic            init_done_q, init_done_d;

    // FSM state, fill counter and done flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
        end
    end

    // Walk the array once, then park in READY until the next reset.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        unique case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + IdxW'(1);
                if (init_cnt_q == IdxW'(Depth - 1)) begin
                    state_d     = READY;
                    init_cnt_d  = '0;
                    init_done_d = 1'b1;
                end
            end
            READY: begin
                init_done_d = 1'b1;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    logic             addr_ok, accept, rd_req, rd_acc, wr_acc;
    logic             mem_we;
    logic [IdxW-1:0]  mem_idx;
    logic [WordW-1:0] mem_wdata, mem_rdata;

    // Address check and array port muxing; init owns the array while filling.
    always_comb begin
        addr_ok   = (64'(sram_addr_i) < 64'(Depth));
        accept    = (state_q == READY) && addr_ok;
        rd_req    = sram_req_i && !sram_write_i;
        rd_acc    = rd_req && accept;
        wr_acc    = sram_req_i && sram_write_i && accept;
        mem_we    = (state_q == INIT) || wr_acc;
        mem_idx   = (state_q == INIT) ? init_cnt_q : sram_addr_i[IdxW-1:0];
        mem_wdata = (state_q == INIT) ? '0
                  : {(^sram_wdata_i) ^ inj_perr_i, sram_wdata_i};
    end

    prim_sram_responder_mem #(
        .Depth (Depth),
        .Width (WordW),
        .IdxW  (IdxW)
    ) u_mem (
        .clk   (clk_i),
        .we    (mem_we),
        .re    (rd_acc),
        .idx   (mem_idx),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    logic  s0_valid_q, s0_rej_q;
    resp_t s0_c, resp_out;

    // First response stage, aligned with the registered array read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s0_valid_q <= 1'b0;
            s0_rej_q   <= 1'b0;
        end else begin
            s0_valid_q <= rd_req;
            s0_rej_q   <= rd_req && !accept;
        end
    end

    // Build the response; data and error stay zero unless valid.
    always_comb begin
        s0_c = '0;
        if (s0_valid_q) begin
            s0_c.valid = 1'b1;
            if (s0_rej_q) begin
                s0_c.err = ErrReject;
            end else begin
                s0_c.data = mem_rdata[SramDw-1:0];
                s0_c.err  = ErrNone | ErrW'(^mem_rdata);
            end
        end
    end

    if (Latency == 1) begin : g_lat1
        assign resp_out = s0_c;
    end else begin : g_pipe
        resp_t pipe_q [Latency-1];

        // Remaining Latency-1 stages of the response shift pipe.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < int'(Latency) - 1; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0] <= s0_c;
                for (int i = 1; i < int'(Latency) - 1; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign resp_out = pipe_q[Latency-2];
    end

    assign sram_rvalid_o = resp_out.valid;
    assign sram_rdata_o  = resp_out.data;
    assign sram_rerror_o = resp_out.err;
    assign init_done_o   = init_done_q;

    logic [Latency-1:0] rd_hist_q;

    // Every rvalid must trace back to a read request exactly Latency cycles earlier.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_hist_q <= '0;
        end else begin
            assert (!sram_rvalid_o || rd_hist_q[Latency-1]);
            rd_hist_q <= (rd_hist_q << 1) | Latency'(rd_req);
        end
    end

endmodule

// File: tb/tb_prim_sram_responder.sv
// Directed bench: two responders (Depth 16, latency 1 and 3) share one stimulus.
module tb_prim_sram_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, write, inj;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        rvalid1, rvalid3, done1, done3;
    logic [31:0] rdata1, rdata3;
    logic [1:0]  rerr1, rerr3;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    always #5 clk = ~clk;

    prim_sram_responder #(.SramDw(32), .SramAw(12), .Depth(16), .Latency(1)) u_dut1 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .sram_req_i    (req),
        .sram_addr_i   (addr),
        .sram_write_i  (write),
        .sram_wdata_i  (wdata),
        .inj_perr_i    (inj),
        .sram_rvalid_o (rvalid1),
        .sram_rdata_o  (rdata1),
        .sram_rerror_o (rerr1),
        .init_done_o   (done1)
    );

    prim_sram_responder #(.SramDw(32), .SramAw(12), .Depth(16), .Latency(3)) u_dut3 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .sram_req_i    (req),
        .sram_addr_i   (addr),
        .sram_write_i  (write),
        .sram_wdata_i  (wdata),
        .inj_perr_i    (inj),
        .sram_rvalid_o (rvalid3),
        .sram_rdata_o  (rdata3),
        .sram_rerror_o (rerr3),
        .init_done_o   (done3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle;
        req   = 1'b0;
        write = 1'b0;
        inj   = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    // One-cycle write; writes never produce a response.
    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic i);
        req   = 1'b1;
        write = 1'b1;
        addr  = a;
        wdata = d;
        inj   = i;
        tick();
        idle();
        chk("wr_no_rvalid1", 32'(rvalid1), 32'd0);
    endtask

    // One-cycle read; checks latency-1 and latency-3 responses, then the drain.
    task automatic rd(input string tag, input logic [11:0] a,
                      input logic [31:0] d, input logic [1:0] e);
        req   = 1'b1;
        write = 1'b0;
        addr  = a;
        tick();
        idle();
        chk({tag, "_v1"}, 32'(rvalid1), 32'd1);
        chk({tag, "_d1"}, rdata1, d);
        chk({tag, "_e1"}, 32'(rerr1), 32'(e));
        chk({tag, "_v3_early"}, 32'(rvalid3), 32'd0);
        tick();
        tick();
        chk({tag, "_v3"}, 32'(rvalid3), 32'd1);
        chk({tag, "_d3"}, rdata3, d);
        chk({tag, "_e3"}, 32'(rerr3), 32'(e));
        tick();
        chk({tag, "_v3_end"}, 32'(rvalid3), 32'd0);
        chk({tag, "_d3_end"}, rdata3, 32'd0);
        chk({tag, "_v1_end"}, 32'(rvalid1), 32'd0);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_rvalid1", 32'(rvalid1), 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_rerr1", 32'(rerr1), 32'd0);
        chk("rst_done1", 32'(done1), 32'd0);
        chk("rst_rvalid3", 32'(rvalid3), 32'd0);
        chk("rst_done3", 32'(done3), 32'd0);

        // Release reset; the next edge is init cycle 0.
        rst_n = 1'b1;
        cyc   = 0;
        tick();
        tick();
        rd("t1_init_read", 12'd3, 32'd0, 2'b10);
        while (cyc < 15) tick();
        chk("t1_done1_c15", 32'(done1), 32'd0);
        chk("t1_done3_c15", 32'(done3), 32'd0);
        tick();
        chk("t1_done1_c16", 32'(done1), 32'd1);
        chk("t1_done3_c16", 32'(done3), 32'd1);

        // Write then read the following cycle.
        wr(12'd5, 32'hDEADBEEF, 1'b0);
        rd("t2_rd5", 12'd5, 32'hDEADBEEF, 2'b00);

        // Back-to-back reads of three distinct words.
        wr(12'd1, 32'h11, 1'b0);
        wr(12'd2, 32'h22, 1'b0);
        wr(12'd3, 32'h33, 1'b0);
        req   = 1'b1;
        write = 1'b0;
        addr  = 12'd1;
        tick();
        addr = 12'd2;
        chk("t3_v1_a", 32'(rvalid1), 32'd1);
        chk("t3_d1_a", rdata1, 32'h11);
        chk("t3_v3_a", 32'(rvalid3), 32'd0);
        tick();
        addr = 12'd3;
        chk("t3_d1_b", rdata1, 32'h22);
        chk("t3_v3_b", 32'(rvalid3), 32'd0);
        tick();
        idle();
        chk("t3_d1_c", rdata1, 32'h33);
        chk("t3_v3_c", 32'(rvalid3), 32'd1);
        chk("t3_d3_c", rdata3, 32'h11);
        tick();
        chk("t3_v1_d", 32'(rvalid1), 32'd0);
        chk("t3_v3_d", 32'(rvalid3), 32'd1);
        chk("t3_d3_d", rdata3, 32'h22);
        tick();
        chk("t3_v3_e", 32'(rvalid3), 32'd1);
        chk("t3_d3_e", rdata3, 32'h33);
        tick();
        chk("t3_v3_f", 32'(rvalid3), 32'd0);

        // Parity injection and recovery.
        wr(12'd7, 32'hA5, 1'b1);
        rd("t4_perr", 12'd7, 32'hA5, 2'b01);
        wr(12'd7, 32'hA5, 1'b0);
        rd("t4_clean", 12'd7, 32'hA5, 2'b00);

        // Out-of-range write is dropped and the aliasing word is untouched.
        wr(12'd20, 32'hCAFEF00D, 1'b0);
        rd("t5_oob", 12'd20, 32'd0, 2'b10);
        rd("t5_alias", 12'd4, 32'd0, 2'b00);

        // Reset with two reads in flight on the latency-3 instance.
        req   = 1'b1;
        write = 1'b0;
        addr  = 12'd1;
        tick();
        addr = 12'd2;
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_v1", 32'(rvalid1), 32'd0);
        chk("t6_rst_v3", 32'(rvalid3), 32'd0);
        chk("t6_rst_d3", rdata3, 32'd0);
        tick();
        tick();
        chk("t6_rst_v3_b", 32'(rvalid3), 32'd0);
        chk("t6_rst_done1", 32'(done1), 32'd0);
        rst_n = 1'b1;
        cyc   = 0;
        while (!done1 && cyc < 40) begin
            tick();
            chk("t6_quiet", 32'({rvalid1, rvalid3}), 32'd0);
        end
        chk("t6_init_len", 32'(cyc), 32'd16);
        chk("t6_done3", 32'(done3), 32'd1);
        for (int a = 0; a < 16; a++) begin
            rd("t6_zero", 12'(a), 32'd0, 2'b00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
